// File: rtl/game_input_pkg.sv
// Shared types and helpers for the keyboard-to-game command front end.
package game_input_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } arb_state_e;

    localparam int unsigned CMD_NONE = 0;

    // Command codes are key index + 1 so that zero can mean "no command".
    function automatic int unsigned cmd_code(input int unsigned index);
        return index + 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hold_counter.sv
// Saturating counter of consecutive high cycles on a level input, with a flag
// that announces the threshold will be held after the coming clock edge.
module hold_counter #(
    parameter int THRESH = 5,
    parameter int CW     = $clog2(THRESH + 1)
) (
    input  logic clk,
    input  logic clrn,
    input  logic level,
    output logic reach_next
);

    localparam logic [CW-1:0] THR = CW'(THRESH);

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = '0;
        if (level) begin
            count_next = (count == THR) ? THR : count + CW'(1);
        end
        reach_next = level && (count_next == THR);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order the always blocks run in.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/key_command_arbiter.sv
// Prioritised key-to-command front end with delayed auto-repeat, a one-entry
// valid/ready output slot and a long-press game reset.
module key_command_arbiter
    import game_input_pkg::*;
#(
    parameter  int NUM_KEYS   = 4,
    parameter  int RESET_KEY  = 2,
    parameter  int DAS_DELAY  = 8,
    parameter  int ARR_PERIOD = 3,
    parameter  int RST_HOLD   = 5,
    localparam int CMD_W      = $clog2(NUM_KEYS + 1)
) (
    input  logic                clk,
    input  logic                clrn,
    input  logic [NUM_KEYS-1:0] key_lvl,
    output logic [CMD_W-1:0]    cmd,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic                game_rst_n,
    output logic [7:0]          drop_cnt
);

    localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int CW = $clog2(max3(DAS_DELAY, ARR_PERIOD, RST_HOLD) + 1);

    localparam logic [CW-1:0] CNT_DAS = CW'(DAS_DELAY);
    localparam logic [CW-1:0] CNT_ARR = CW'(ARR_PERIOD);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    arb_state_e    state, state_next;
    logic          sel_valid;
    logic [KW-1:0] sel_idx;
    logic [KW-1:0] cur_sel;
    logic [CW-1:0] cnt, cnt_next;
    logic          press_evt, rpt_evt;
    logic          slot_take;
    logic          rst_reach_next;

    // Lowest-index key wins; the reset key never competes.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (i != RESET_KEY && key_lvl[i]) begin
                sel_valid = 1'b1;
                sel_idx   = KW'(i);
            end
        end
    end

    hold_counter #(
        .THRESH (RST_HOLD),
        .CW     (CW)
    ) u_rst_hold (
        .clk        (clk),
        .clrn       (clrn),
        .level      (key_lvl[RESET_KEY]),
        .reach_next (rst_reach_next)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!game_rst_n || !sel_valid) begin
            state_next = ST_IDLE;
        end else if (state == ST_IDLE || sel_idx != cur_sel) begin
            state_next = ST_DELAY;
        end else if (cnt == CNT_ONE) begin
            state_next = ST_REPEAT;
        end
    end

    always_comb begin
        press_evt = game_rst_n && sel_valid && (state == ST_IDLE || sel_idx != cur_sel);
        rpt_evt   = game_rst_n && sel_valid && state != ST_IDLE &&
                    sel_idx == cur_sel && cnt == CNT_ONE;
        cnt_next  = cnt;
        if (press_evt) begin
            cnt_next = CNT_DAS;
        end else if (rpt_evt) begin
            cnt_next = CNT_ARR;
        end else if (state_next == ST_IDLE) begin
            cnt_next = '0;
        end else if (cnt != '0) begin
            cnt_next = cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt     <= '0;
            cur_sel <= '0;
        end else begin
            cnt <= cnt_next;
            if (press_evt) begin
                cur_sel <= sel_idx;
            end
        end
    end

    // A repeat only lands when the slot is free or being drained this cycle.
    assign slot_take = !cmd_valid || cmd_ready;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cmd       <= CMD_W'(CMD_NONE);
            cmd_valid <= 1'b0;
            drop_cnt  <= '0;
        end else if (!game_rst_n) begin
            cmd       <= CMD_W'(CMD_NONE);
            cmd_valid <= 1'b0;
        end else if (press_evt) begin
            cmd       <= CMD_W'(cmd_code(int'(sel_idx)));
            cmd_valid <= 1'b1;
        end else if (rpt_evt) begin
            if (slot_take) begin
                cmd       <= CMD_W'(cmd_code(int'(cur_sel)));
                cmd_valid <= 1'b1;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
        end
    end

    // Low during and just after clrn; released on the first edge unless the
    // reset key has already been held long enough.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            game_rst_n <= 1'b0;
        end else begin
            game_rst_n <= !rst_reach_next;
        end
    end

endmodule

// File: tb/tb_key_command_arbiter.sv
// Scoreboard bench for key_command_arbiter: a cycle model built from hold ages
// predicts accepted commands, a negedge monitor pops and compares them.
module tb_key_command_arbiter;

    localparam int NK = 4;
    localparam int RK = 2;
    localparam int D  = 8;
    localparam int A  = 3;
    localparam int H  = 5;

    logic          clk = 1'b0;
    logic          clrn;
    logic [NK-1:0] key_lvl;
    logic [2:0]    cmd;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          game_rst_n;
    logic [7:0]    drop_cnt;

    key_command_arbiter #(
        .NUM_KEYS   (NK),
        .RESET_KEY  (RK),
        .DAS_DELAY  (D),
        .ARR_PERIOD (A),
        .RST_HOLD   (H)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .key_lvl    (key_lvl),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .game_rst_n (game_rst_n),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    int exp_q[$];
    int m_valid, m_cmd, m_drop, m_grst;
    int n_valid, n_cmd, n_drop, n_grst;
    int hold_sel, age, hold_cnt;
    int acc_cnt = 0;
    int rst_low_cnt = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int arb(input logic [NK-1:0] k);
        for (int i = 0; i < NK; i++) begin
            if (i != RK && k[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_cmd = 0; m_drop = 0; m_grst = 0;
        n_valid = 0; n_cmd = 0; n_drop = 0; n_grst = 0;
        hold_sel = -1; age = 0; hold_cnt = 0;
        exp_q.delete();
    endtask

    // Predicts the state after the coming edge from hold age since the press.
    task automatic model_edge(input logic [NK-1:0] keys, input logic ready);
        int sel;
        bit press, rpt;
        sel = arb(keys);
        press = 0;
        rpt = 0;
        if (m_valid != 0 && ready) exp_q.push_back(m_cmd);
        if (m_grst == 0 || sel < 0) begin
            hold_sel = -1;
        end else if (sel != hold_sel) begin
            press = 1; hold_sel = sel; age = 0;
        end else begin
            age++;
            rpt = (age == D) || (age > D && (age - D) % A == 0);
        end
        n_valid = m_valid; n_cmd = m_cmd; n_drop = m_drop;
        if (m_grst == 0) begin
            n_valid = 0;
        end else if (press) begin
            n_valid = 1; n_cmd = sel + 1;
        end else if (rpt) begin
            if (m_valid == 0 || ready) begin
                n_valid = 1; n_cmd = hold_sel + 1;
            end else if (m_drop < 255) begin
                n_drop = m_drop + 1;
            end
        end else if (m_valid != 0 && ready) begin
            n_valid = 0;
        end
        hold_cnt = keys[RK] ? ((hold_cnt + 1 > H) ? H : hold_cnt + 1) : 0;
        n_grst = (hold_cnt == H) ? 0 : 1;
    endtask

    // Called at posedge+1: commit last prediction, drive, predict next edge.
    task automatic step(input logic [NK-1:0] keys, input logic ready);
        m_valid = n_valid; m_cmd = n_cmd; m_drop = n_drop; m_grst = n_grst;
        key_lvl   = keys;
        cmd_ready = ready;
        model_edge(keys, ready);
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [NK-1:0] keys, input logic ready, input int n);
        for (int i = 0; i < n; i++) step(keys, ready);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd"}, cmd, 0);
        check({tag, "_cmd_valid"}, cmd_valid, 0);
        check({tag, "_game_rst_n"}, game_rst_n, 0);
        check({tag, "_drop_cnt"}, drop_cnt, 0);
    endtask

    task automatic do_reset(input string tag);
        #1;
        clrn = 1'b0;
        #1;
        check_reset_outputs(tag);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        clrn = 1'b1;
    endtask

    always @(negedge clk) begin
        check("cmd_valid", cmd_valid, m_valid);
        check("game_rst_n", game_rst_n, m_grst);
        check("drop_cnt", drop_cnt, m_drop);
        if (!game_rst_n) rst_low_cnt++;
        if (cmd_valid && cmd_ready) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL cmd_spurious: got cmd %0d expected no transfer at %0t", cmd, $time);
            end else begin
                check("cmd", cmd, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0, d0, r0;
        logic [NK-1:0] k;
        logic rdy;
        clrn = 1'b0;
        key_lvl = '0;
        cmd_ready = 1'b1;
        model_reset();
        #3;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1;
        clrn = 1'b1;
        hold('0, 1'b1, 3);

        // Tap: one command, no repeat.
        a0 = acc_cnt;
        hold(4'b0001, 1'b1, 2);
        hold('0, 1'b1, 4);
        check("tap_events", acc_cnt - a0, 1);

        // Hold key3 for 20 cycles: press plus repeats at 8, 11, 14, 17.
        a0 = acc_cnt;
        hold(4'b1000, 1'b1, 20);
        hold('0, 1'b1, 6);
        check("key3_events", acc_cnt - a0, 5);

        // Priority switch and back.
        a0 = acc_cnt;
        hold(4'b0010, 1'b1, 4);
        hold(4'b0011, 1'b1, 12);
        hold(4'b0010, 1'b1, 3);
        hold('0, 1'b1, 4);
        check("switch_events", acc_cnt - a0, 5);

        // Stalled consumer: repeats are dropped, press overwrites.
        d0 = drop_cnt;
        hold(4'b0001, 1'b0, 20);
        check("stall_drops", drop_cnt - d0, 4);
        check("stall_cmd", cmd, 1);
        hold(4'b0010, 1'b0, 1);
        check("overwrite_cmd", cmd, 2);
        hold('0, 1'b1, 3);

        // Reset key: short hold has no effect, long hold gives 3 low cycles.
        a0 = acc_cnt;
        r0 = rst_low_cnt;
        hold(4'b0100, 1'b1, 4);
        hold('0, 1'b1, 3);
        check("rstkey_short_low", rst_low_cnt - r0, 0);
        r0 = rst_low_cnt;
        hold(4'b0100, 1'b1, 7);
        hold('0, 1'b1, 3);
        check("rstkey_long_low", rst_low_cnt - r0, 3);
        check("rstkey_no_cmd", acc_cnt - a0, 0);

        // clrn during REPEAT with a pending command, key0 still held after.
        hold(4'b0001, 1'b0, 12);
        do_reset("midrst");
        a0 = acc_cnt;
        hold(4'b0001, 1'b1, 3);
        check("post_reset_press", acc_cnt - a0, 1);
        hold('0, 1'b1, 3);

        // Randomised phase with sticky keys and a bursty consumer.
        k = '0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                k = NK'($urandom_range(0, 15));
                if ($urandom_range(0, 3) != 0) k[RK] = 1'b0;
            end
            rdy = ($urandom_range(0, 3) != 0);
            step(k, rdy);
            if (i == 400) do_reset("rnd_rst");
        end

        hold('0, 1'b1, 4);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
